// File: rtl/voter_ballot_unit.sv
// voter_ballot_unit: debounces three ballot buttons and issues at most one
// registered vote pulse per officer-authorised session.
module voter_ballot_unit #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 200,
   parameter int LOCKOUT_CYCLES  = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic voter_auth,
   input  logic btn_a,
   input  logic btn_b,
   input  logic btn_c,
   input  logic voting_enabled,
   input  logic busy,
   output logic vote_a,
   output logic vote_b,
   output logic vote_c,
   output logic session_active,
   output logic vote_cast,
   output logic timeout,
   output logic multi_press
);
   typedef enum logic [2:0] {IDLE, ARMED, DEBOUNCE, ISSUE, LOCKOUT} state_t;
   state_t state, state_nx;
   logic [3:0] dcnt, dcnt_nx, lcnt, lcnt_nx;
   logic [7:0] tcnt, tcnt_nx, t_inc;
   logic [2:0] cap, cap_nx, vote, vote_nx, btn;
   logic released, released_nx, timeout_nx, multi_nx;
   logic one_hot, multi, t_hit, d_hit;
   assign btn     = {btn_c, btn_b, btn_a};
   assign one_hot = (btn != 3'd0) && ((btn & (btn - 3'd1)) == 3'd0);
   assign multi   = (btn != 3'd0) && !one_hot;
   assign t_hit   = tcnt == 8'(TIMEOUT_CYCLES - 1);
   assign d_hit   = dcnt == 4'(DEBOUNCE_CYCLES - 1);
   assign t_inc   = (tcnt == 8'hff) ? tcnt : tcnt + 8'd1;
   assign {vote_c, vote_b, vote_a} = vote;
   assign session_active = (state == ARMED) || (state == DEBOUNCE) || (state == ISSUE);
   assign vote_cast = state == LOCKOUT;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         dcnt        <= '0;
         lcnt        <= '0;
         tcnt        <= '0;
         cap         <= '0;
         released    <= 1'b0;
         vote        <= '0;
         timeout     <= 1'b0;
         multi_press <= 1'b0;
      end else begin
         state       <= state_nx;
         dcnt        <= dcnt_nx;
         lcnt        <= lcnt_nx;
         tcnt        <= tcnt_nx;
         cap         <= cap_nx;
         released    <= released_nx;
         vote        <= vote_nx;
         timeout     <= timeout_nx;
         multi_press <= multi_nx;
      end
   end
   // Abort beats timeout, timeout beats debounce completion.
   always_comb begin
      state_nx    = state;
      dcnt_nx     = dcnt;
      lcnt_nx     = lcnt;
      tcnt_nx     = tcnt;
      cap_nx      = cap;
      released_nx = released;
      vote_nx     = '0;
      timeout_nx  = 1'b0;
      multi_nx    = 1'b0;
      case (state)
         IDLE: begin
            if (voter_auth && voting_enabled) begin
               state_nx    = ARMED;
               tcnt_nx     = '0;
               dcnt_nx     = '0;
               released_nx = 1'b0;
            end
         end
         ARMED: begin
            if (!voting_enabled) state_nx = IDLE;
            else if (t_hit) begin
               state_nx   = IDLE;
               timeout_nx = 1'b1;
            end else begin
               tcnt_nx = t_inc;
               if (btn == 3'd0) released_nx = 1'b1;
               else if (released && one_hot) begin
                  cap_nx   = btn;
                  dcnt_nx  = 4'd1;
                  state_nx = (DEBOUNCE_CYCLES == 1) ? ISSUE : DEBOUNCE;
               end else if (released) multi_nx = multi;
            end
         end
         DEBOUNCE: begin
            if (!voting_enabled) state_nx = IDLE;
            else if (t_hit) begin
               state_nx   = IDLE;
               timeout_nx = 1'b1;
            end else begin
               tcnt_nx = t_inc;
               if (btn == cap) begin
                  dcnt_nx  = (dcnt == 4'hf) ? dcnt : dcnt + 4'd1;
                  state_nx = d_hit ? ISSUE : DEBOUNCE;
               end else begin
                  state_nx = ARMED;
                  dcnt_nx  = '0;
                  multi_nx = multi;
               end
            end
         end
         ISSUE: begin
            if (!voting_enabled) state_nx = IDLE;
            else if (!busy) begin
               vote_nx  = cap;
               lcnt_nx  = '0;
               state_nx = LOCKOUT;
            end
         end
         LOCKOUT: begin
            if (lcnt == 4'(LOCKOUT_CYCLES - 1)) state_nx = IDLE;
            else lcnt_nx = lcnt + 4'd1;
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_voter_ballot_unit.sv
// tb_voter_ballot_unit: directed scenarios plus random traffic checked each
// cycle against a behavioural session model.
module tb_voter_ballot_unit;
   localparam int DEB = 4, TMO = 200, LCK = 8;
   logic clk = 1'b0;
   logic reset, voter_auth, btn_a, btn_b, btn_c, voting_enabled, busy;
   logic vote_a, vote_b, vote_c, session_active, vote_cast, timeout, multi_press;
   int n_checks = 0, n_fail = 0;
   typedef enum int {S_IDLE, S_ARM, S_DEB, S_ISS, S_LOCK} phase_t;
   phase_t ph = S_IDLE;
   int waited, stable, lock_left;
   bit released, e_to, e_mp;
   logic [2:0] pick, e_vote;
   int t_vote[3], t_to, t_mp, t_cast, last_vote_step, step_no;

   always #5 clk = ~clk;

   voter_ballot_unit #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .LOCKOUT_CYCLES(LCK)) dut (
      .clk(clk), .reset(reset), .voter_auth(voter_auth), .btn_a(btn_a), .btn_b(btn_b),
      .btn_c(btn_c), .voting_enabled(voting_enabled), .busy(busy), .vote_a(vote_a),
      .vote_b(vote_b), .vote_c(vote_c), .session_active(session_active),
      .vote_cast(vote_cast), .timeout(timeout), .multi_press(multi_press));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] outs();
      return {vote_c, vote_b, vote_a, session_active, vote_cast, timeout, multi_press};
   endfunction

   function automatic logic [6:0] exp_outs();
      return {e_vote, ph == S_ARM || ph == S_DEB || ph == S_ISS, ph == S_LOCK, e_to, e_mp};
   endfunction

   // One clock of session rules, applied to the inputs present at the edge.
   task automatic model_step();
      logic [2:0] b;
      int n;
      b = {btn_c, btn_b, btn_a};
      n = $countones(b);
      e_vote = 3'd0;
      e_to = 0;
      e_mp = 0;
      if (ph == S_IDLE) begin
         if (voter_auth && voting_enabled) begin
            ph = S_ARM;
            waited = 0;
            released = 0;
         end
      end else if (ph == S_ARM || ph == S_DEB) begin
         if (!voting_enabled) ph = S_IDLE;
         else if (waited == TMO - 1) begin
            ph = S_IDLE;
            e_to = 1;
         end else begin
            waited++;
            if (ph == S_ARM) begin
               if (n == 0) released = 1;
               else if (released && n == 1) begin
                  pick = b;
                  stable = 1;
                  ph = (DEB == 1) ? S_ISS : S_DEB;
               end else if (released) e_mp = 1;
            end else if (b == pick) begin
               stable++;
               if (stable == DEB) ph = S_ISS;
            end else begin
               ph = S_ARM;
               e_mp = n > 1;
            end
         end
      end else if (ph == S_ISS) begin
         if (!voting_enabled) ph = S_IDLE;
         else if (!busy) begin
            e_vote = pick;
            ph = S_LOCK;
            lock_left = LCK;
         end
      end else begin
         lock_left--;
         if (lock_left == 0) ph = S_IDLE;
      end
   endtask

   task automatic step(input bit auth, input bit a, input bit b, input bit c);
      voter_auth = auth;
      btn_a = a;
      btn_b = b;
      btn_c = c;
      @(posedge clk);
      #1;
      model_step();
      check("outs", outs(), exp_outs());
      step_no++;
      t_vote[0] += vote_a;
      t_vote[1] += vote_b;
      t_vote[2] += vote_c;
      t_to += timeout;
      t_mp += multi_press;
      t_cast += vote_cast;
      if (vote_a | vote_b | vote_c) last_vote_step = step_no;
   endtask

   task automatic clear_tally();
      t_vote = '{0, 0, 0};
      t_to = 0;
      t_mp = 0;
      t_cast = 0;
      last_vote_step = 0;
      step_no = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      ph = S_IDLE;
      e_vote = 3'd0;
      e_to = 0;
      e_mp = 0;
      check("async_reset", outs(), 7'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic arm();
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
   endtask

   logic [2:0] tbl [12] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd4};
   bit bounce [7] = '{1, 1, 0, 1, 1, 1, 1};

   initial begin
      logic [2:0] cur;
      reset = 1'b0;
      voter_auth = 0;
      btn_a = 0;
      btn_b = 0;
      btn_c = 0;
      voting_enabled = 1;
      busy = 0;
      do_reset();
      // basic vote on B with latency and lockout length
      arm();
      clear_tally();
      repeat (6) step(0, 0, 1, 0);
      repeat (12) step(0, 0, 0, 0);
      check("t1_vote_b_count", t_vote[1], 1);
      check("t1_latency", last_vote_step, 5);
      check("t1_cast_len", t_cast, LCK);
      check("t1_other_votes", t_vote[0] + t_vote[2], 0);
      check("t1_session_end", session_active, 0);
      // bounce restarts debounce; auth during lockout ignored
      arm();
      clear_tally();
      foreach (bounce[i]) step(0, bounce[i], 0, 0);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      repeat (12) step(0, 0, 0, 0);
      check("t2_vote_a_count", t_vote[0], 1);
      check("t2_vote_step", last_vote_step, 8);
      check("t2_total_votes", t_vote[0] + t_vote[1] + t_vote[2], 1);
      check("t2_session_end", session_active, 0);
      // multi press then clean C
      arm();
      clear_tally();
      repeat (3) step(0, 1, 0, 1);
      check("t3_multi_count", t_mp, 3);
      check("t3_no_vote", t_vote[0] + t_vote[1] + t_vote[2], 0);
      step(0, 0, 0, 0);
      repeat (4) step(0, 0, 0, 1);
      repeat (12) step(0, 0, 0, 0);
      check("t3_vote_c_count", t_vote[2], 1);
      check("t3_total_votes", t_vote[0] + t_vote[1] + t_vote[2], 1);
      // idle timeout
      step(1, 0, 0, 0);
      clear_tally();
      repeat (TMO) step(0, 0, 0, 0);
      check("t4_timeout_pulse", timeout, 1);
      check("t4_timeout_count", t_to, 1);
      check("t4_session_off", session_active, 0);
      step(0, 0, 0, 0);
      check("t4_timeout_single", timeout, 0);
      // button held across arming never counts
      step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      clear_tally();
      repeat (TMO + 5) step(0, 1, 0, 0);
      check("t4b_timeout_count", t_to, 1);
      check("t4b_no_vote", t_vote[0] + t_vote[1] + t_vote[2], 0);
      step(0, 0, 0, 0);
      // busy holds an accepted vote past the timeout count
      step(1, 0, 0, 0);
      repeat (190) step(0, 0, 0, 0);
      busy = 1;
      clear_tally();
      repeat (4) step(0, 1, 0, 0);
      repeat (10) step(0, 0, 0, 0);
      check("t5_no_vote_busy", t_vote[0] + t_vote[1] + t_vote[2], 0);
      check("t5_no_timeout", t_to, 0);
      check("t5_session_held", session_active, 1);
      busy = 0;
      step(0, 0, 0, 0);
      check("t5_vote_a", vote_a, 1);
      repeat (10) step(0, 0, 0, 0);
      // abort in ISSUE while busy
      busy = 1;
      arm();
      clear_tally();
      repeat (4) step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      voting_enabled = 0;
      busy = 0;
      step(0, 0, 0, 0);
      check("t6_abort_idle", session_active, 0);
      voting_enabled = 1;
      repeat (3) step(0, 0, 0, 0);
      check("t6_abort_no_vote", t_vote[0] + t_vote[1] + t_vote[2], 0);
      // reset during the vote pulse
      arm();
      repeat (4) step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      check("t6_vote_pulse", vote_a, 1);
      do_reset();
      check("t6_after_reset", outs(), 7'd0);
      repeat (3) step(0, 0, 0, 0);
      // random traffic
      cur = 3'd0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 3) == 0) cur = tbl[$urandom_range(0, 11)];
         if ($urandom_range(0, 99) == 0) voting_enabled = $urandom_range(0, 9) != 0;
         busy = $urandom_range(0, 2) == 0;
         if ($urandom_range(0, 999) == 0) do_reset();
         else step($urandom_range(0, 24) == 0, cur[0], cur[1], cur[2]);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
